// File: rtl/credit_rr_output_arbiter_if.sv
// Handshake bundle between the five input buffers, the downstream credit
// return path and one router output arbiter.
interface credit_rr_output_arbiter_if #(
   parameter int CW = 3
);
   logic [4:0]    req;
   logic [4:0]    tail;
   logic          credit_in;
   logic [4:0]    grant;
   logic [4:0]    Xbar_sel;
   logic          valid_out;
   logic [CW-1:0] credits;
   logic          busy;
   logic          credit_err;

   modport master (
      output req, tail, credit_in,
      input  grant, Xbar_sel, valid_out, credits, busy, credit_err
   );

   modport slave (
      input  req, tail, credit_in,
      output grant, Xbar_sel, valid_out, credits, busy, credit_err
   );
endinterface

// File: rtl/credit_rr_output_arbiter.sv
// Round-robin packet arbiter for one mesh router output (inputs L,N,E,W,S),
// holding the output per packet and pacing flits against downstream credits.
//
// state  | meaning
// IDLE   | no packet owns the output; pick next winner from rr pointer
// LOCKED | output owned by winner until its tail flit transfers
module credit_rr_output_arbiter #(
   parameter int CREDITS = 4,
   parameter int CW      = 3
) (
   input logic                          clk,
   input logic                          rst,
   credit_rr_output_arbiter_if.slave    bus
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

   state_t        state;
   logic [2:0]    ptr;
   logic [2:0]    winner;
   logic [4:0]    xbar_q;
   logic [CW-1:0] credits_q;
   logic          credit_err_q;

   logic [2:0]    pick;
   logic          pick_found;
   logic [4:0]    grant_c;
   logic          transfer;
   logic [3:0]    scan_sum;
   logic [2:0]    scan_idx;

   // First requester at or above the pointer, wrapping modulo 5.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      scan_sum   = '0;
      scan_idx   = '0;
      for (int i = 0; i < 5; i++) begin
         scan_sum = {1'b0, ptr} + 4'(i);
         scan_idx = (scan_sum >= 4'd5) ? 3'(scan_sum - 4'd5) : scan_sum[2:0];
         if (!pick_found && bus.req[scan_idx]) begin
            pick_found = 1'b1;
            pick       = scan_idx;
         end
      end
   end

   // Uses the registered credit count, so a same-cycle credit_in cannot unblock a flit.
   always_comb begin
      grant_c = '0;
      if (state == LOCKED && bus.req[winner] && credits_q != '0)
         grant_c[winner] = 1'b1;
   end

   assign transfer = |grant_c;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         ptr          <= '0;
         winner       <= '0;
         xbar_q       <= '0;
         credits_q    <= CREDITS_MAX;
         credit_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  winner <= pick;
                  xbar_q <= 5'b00001 << pick;
                  state  <= LOCKED;
               end
            end
            LOCKED: begin
               if (transfer && bus.tail[winner]) begin
                  state  <= IDLE;
                  xbar_q <= '0;
                  ptr    <= (winner == 3'd4) ? 3'd0 : winner + 3'd1;
               end
            end
            default: begin
               state  <= IDLE;
               xbar_q <= '0;
            end
         endcase

         if (transfer && !bus.credit_in) begin
            credits_q <= credits_q - 1'b1;
         end else if (bus.credit_in && !transfer) begin
            if (credits_q == CREDITS_MAX)
               credit_err_q <= 1'b1;
            else
               credits_q <= credits_q + 1'b1;
         end
      end
   end

   assign bus.grant      = grant_c;
   assign bus.valid_out  = transfer;
   assign bus.Xbar_sel   = xbar_q;
   assign bus.busy       = (state == LOCKED);
   assign bus.credits    = credits_q;
   assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_credit_rr_output_arbiter.sv
// Directed-vector bench for credit_rr_output_arbiter: round-robin order,
// credit stall, bubbles, credit counter corner cases and mid-packet reset.
module tb_credit_rr_output_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   credit_rr_output_arbiter_if #(.CW(3)) bus ();

   credit_rr_output_arbiter #(.CREDITS(4), .CW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [4:0] e;

   initial begin
      rst = 1'b0;
      bus.req = '0;
      bus.tail = '0;
      bus.credit_in = 1'b0;
      step();
      step();
      #2;
      check("rst_grant", bus.grant, 0);
      check("rst_xbar", bus.Xbar_sel, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_valid", bus.valid_out, 0);
      check("rst_credits", bus.credits, 4);
      check("rst_err", bus.credit_err, 0);
      rst = 1'b1;
      step();

      for (int i = 0; i < 10; i++) begin
         #2;
         check("idle_outs", {bus.busy, bus.grant, bus.Xbar_sel}, 0);
         check("idle_credits", bus.credits, 4);
         step();
      end

      // All inputs request single-flit packets; credit returned with each flit.
      bus.req = 5'b11111;
      bus.tail = 5'b11111;
      for (int c = 0; c < 12; c++) begin
         #2;
         e = (c % 2 == 1) ? 5'(5'b00001 << ((c / 2) % 5)) : 5'b00000;
         check("rr_grant", bus.grant, e);
         check("rr_xbar", bus.Xbar_sel, e);
         bus.credit_in = |bus.grant;
         step();
         bus.credit_in = 1'b0;
      end
      bus.req = '0;
      #2;
      check("rr_credits", bus.credits, 4);
      check("rr_busy", bus.busy, 0);
      step();

      // E sends a 6-flit packet with credits withheld.
      bus.req = 5'b00100;
      bus.tail = '0;
      for (int c = 0; c < 7; c++) begin
         #2;
         check("e_grant", bus.grant, (c >= 1 && c <= 4) ? 5'b00100 : 5'b00000);
         step();
      end
      #2;
      check("stall_credits", bus.credits, 0);
      check("stall_xbar", bus.Xbar_sel, 5'b00100);
      check("stall_busy", bus.busy, 1);
      bus.credit_in = 1'b1;
      check("stall_same_cycle_credit", bus.grant, 0);
      step();
      bus.credit_in = 1'b0;
      #2;
      check("flit5_credits", bus.credits, 1);
      check("flit5_grant", bus.grant, 5'b00100);
      step();
      #2;
      check("stall2_grant", bus.grant, 0);
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      bus.tail = 5'b00100;
      #2;
      check("flit6_grant", bus.grant, 5'b00100);
      step();
      bus.req = 5'b01010;
      bus.tail = '0;
      #2;
      check("after_e_busy", bus.busy, 0);
      check("after_e_credits", bus.credits, 0);
      step();
      #2;
      check("ptr_w_xbar", bus.Xbar_sel, 5'b01000);
      check("ptr_w_nocredit", bus.grant, 0);
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      bus.tail = 5'b01000;
      #2;
      check("w_grant", bus.grant, 5'b01000);
      step();
      bus.req = '0;
      bus.tail = '0;
      for (int i = 0; i < 4; i++) begin
         bus.credit_in = 1'b1;
         step();
      end
      bus.credit_in = 1'b0;
      #2;
      check("refill_credits", bus.credits, 4);
      check("refill_err", bus.credit_err, 0);
      step();

      // N bubbles for 3 cycles while S requests; S must wait.
      bus.req = 5'b00010;
      #2;
      check("n_arb", bus.grant, 0);
      step();
      #2;
      check("n_flit1", bus.grant, 5'b00010);
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      bus.req = 5'b10000;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("bubble_grant", bus.grant, 0);
         check("bubble_xbar", bus.Xbar_sel, 5'b00010);
         step();
      end
      bus.req = 5'b10010;
      bus.tail = 5'b10010;
      #2;
      check("n_tail", bus.grant, 5'b00010);
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      #2;
      check("gap_busy", bus.busy, 0);
      check("gap_grant", bus.grant, 0);
      step();
      #2;
      check("s_xbar", bus.Xbar_sel, 5'b10000);
      check("s_grant", bus.grant, 5'b10000);
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      bus.req = '0;
      bus.tail = '0;
      #2;
      check("s_credits", bus.credits, 4);
      step();

      // Simultaneous transfer and credit return at credits=2, then overflow.
      bus.req = 5'b00001;
      #2;
      check("l_arb", bus.grant, 0);
      step();
      #2;
      check("l_flit1", bus.grant, 5'b00001);
      step();
      #2;
      check("l_flit2", bus.grant, 5'b00001);
      step();
      #2;
      check("l_credits2", bus.credits, 2);
      check("l_flit3", bus.grant, 5'b00001);
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      #2;
      check("xfer_and_credit", bus.credits, 2);
      bus.tail = 5'b00001;
      check("l_tail", bus.grant, 5'b00001);
      step();
      bus.req = '0;
      bus.tail = '0;
      #2;
      check("l_done_credits", bus.credits, 1);
      check("l_done_busy", bus.busy, 0);
      for (int i = 0; i < 3; i++) begin
         bus.credit_in = 1'b1;
         step();
      end
      #2;
      check("full_credits", bus.credits, 4);
      check("full_err_clear", bus.credit_err, 0);
      step();
      bus.credit_in = 1'b0;
      #2;
      check("overflow_credits", bus.credits, 4);
      check("overflow_err", bus.credit_err, 1);
      step();
      step();
      step();
      #2;
      check("err_sticky", bus.credit_err, 1);
      step();

      // Reset while W owns the output at credits=1.
      bus.req = 5'b01000;
      #2;
      check("w2_arb", bus.grant, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         #2;
         check("w2_flit", bus.grant, 5'b01000);
         step();
      end
      #2;
      check("w2_credits", bus.credits, 1);
      check("w2_xbar", bus.Xbar_sel, 5'b01000);
      check("w2_busy", bus.busy, 1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      #2;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_credits", bus.credits, 4);
      check("mid_rst_err", bus.credit_err, 0);
      check("mid_rst_grant", bus.grant, 0);
      check("mid_rst_xbar", bus.Xbar_sel, 0);
      bus.req = 5'b11111;
      step();
      #2;
      check("post_rst_l_wins", bus.Xbar_sel, 5'b00001);
      check("post_rst_grant", bus.grant, 5'b00001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/credit_rr_output_arbiter.md
Name: credit_rr_output_arbiter

Overview:
Per-output-port packet arbiter for the 5-port mesh router (L, N, E, W, S inputs). It shares one router output between the five input buffers using round-robin arbitration. Once a packet wins, the arbiter holds the output for that packet until its tail flit has been sent. It paces each flit against a downstream credit counter, and it drives the one-hot crossbar select for that output.

Parameters:
CREDITS, 4, downstream input-buffer depth in flits; also the credit counter reset value (1..7)
CW, 3, credit counter width; must satisfy 2^CW > CREDITS

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-low reset; sampled on rising clk; 0 = reset
req  input  5  per-input "flit ready for this output"; bit0=L, 1=N, 2=E, 3=W, 4=S
tail  input  5  per-input "current head-of-queue flit is the packet's last"; qualified by req
credit_in  input  1  one-cycle pulse: downstream freed one buffer slot
grant  output  5  one-hot (or zero); flit transfer from that input occurs this cycle
Xbar_sel  output  5  one-hot crossbar select of the locked input; 0 when idle
valid_out  output  1  flit presented downstream this cycle (= |grant)
credits  output  CW  current credit count
busy  output  1  arbiter locked to a packet
credit_err  output  1  sticky: credit_in received while credits == CREDITS

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, credits=CREDITS, rr pointer=0 (L first), winner=0, credit_err=0.
  - grant=0, Xbar_sel=0, valid_out=0, busy=0.
  - Reset mid-packet abandons the packet silently.
- States: IDLE, LOCKED.
- IDLE:
  - Outputs grant=0, Xbar_sel=0, busy=0.
  - If |req, the winner is the first set bit scanning from the pointer upward, wrapping modulo 5.
  - Register the winner; next state = LOCKED.
  - Credits do not gate arbitration.
  - Req=0: stay IDLE.
- LOCKED:
  - busy=1; Xbar_sel = one-hot(winner), registered and stable for the whole packet.
  - grant[winner] = req[winner] && (credits != 0), combinational from registered state, req and credits.
  - All other grant bits are 0.
- Transfer = grant[winner].
  - Transfer with tail[winner]=1: next state = IDLE; pointer = (winner+1) mod 5.
  - Transfer with tail=0: remain LOCKED.
  - req[winner] drops mid-packet (bubble): remain LOCKED, no grant; requests from other inputs are ignored.
- Latency:
  - Req rising in IDLE at cycle t: LOCKED from t+1; first grant no earlier than t+1.
  - Back-to-back packets: the cycle after a tail transfer is an IDLE arbitration cycle, so there is a 1-cycle bubble between packets.
- Credit counter, updated every cycle in any state:
  - Transfer only: credits-1.
  - credit_in only: credits+1, saturating at CREDITS.
  - Both: unchanged.
  - credits==0 and no credit_in: no transfer possible (grant=0).
  - credits==0 with credit_in in the same cycle: grant still 0 this cycle (uses the registered count); credits=1 next cycle.
  - credit_in while credits==CREDITS and no transfer: count holds; credit_err set (cleared only by reset).
- Pointer changes only on a tail transfer, which guarantees starvation freedom: every requester is served within 4 packets.
- Invariants:
  - grant is always one-hot or zero.
  - grant is nonzero only when busy=1 and credits>0.
  - Xbar_sel is one-hot iff busy=1.

Test Plan:
- Reset release, req=5'b00000 -> grant=0, Xbar_sel=0, busy=0, credits=4 held for 10 cycles.
- req=5'b11111, every flit tail=1, credit_in returned each transfer -> winners in order L, N, E, W, S, L; Xbar_sel 00001, 00010, 00100, 01000, 10000, 00001; each grant one cycle, separated by 1 idle cycle.
- Input E sends a 6-flit packet (tail on flit 6), credit_in withheld -> 4 grants, then credits=0 and stall. Pulse credit_in twice -> flits 5 and 6 sent. IDLE afterwards, credits=0, pointer=W.
- Locked to N, req[N] deasserted for 3 cycles mid-packet while req[S]=1 -> no grant, Xbar_sel stays 00010. req[N] returns with tail -> N completes, then S wins.
- Transfer and credit_in in the same cycle at credits=2 -> credits stays 2. credit_in at credits=4 with no transfer -> credits=4, credit_err=1 and sticky.
- rst=0 asserted while LOCKED to W at credits=1 -> next cycle IDLE, credits=4, credit_err=0, grant=0. Then req=5'b11111 -> L wins.
